// File: rtl/sdram_port_arbiter_pkg.sv
// Shared constants for the two-master SDRAM port arbiter: grant encoding,
// master ids carried in the read tag FIFO and the fixed Avalon burst size.
package sdram_arb_pkg;

  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_M0   = 2'd1;
  localparam logic [1:0] GRANT_M1   = 2'd2;

  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;

  localparam logic [7:0] BURSTCOUNT_ONE = 8'h01;
  localparam logic [7:0] M0_BYTEENABLE  = 8'hFF;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Connection between the arbiter and its read tag FIFO.
// Handshake: push/pop are single-cycle strobes; the FIFO drops a push when full
// (unless a pop happens in the same cycle) and drops a pop when empty.
interface sdram_port_arbiter_if #(
  parameter int PENDING_LOG2 = 6
);
  logic                  push;
  logic                  push_id;
  logic                  pop;
  logic                  head;
  logic                  full;
  logic                  empty;
  logic [PENDING_LOG2:0] count;

  modport master (output push, push_id, pop, input head, full, empty, count);
  modport slave  (input push, push_id, pop, output head, full, empty, count);
endinterface

// File: rtl/sdram_port_arbiter_read_tag_fifo.sv
// Register-based FIFO of 1-bit master ids, one entry per outstanding SDRAM read.
module read_tag_fifo #(
  parameter int MAX_PENDING  = 64,
  parameter int PENDING_LOG2 = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sdram_port_arbiter_if.slave  tag
);

  logic [MAX_PENDING-1:0]  mem_q;
  logic [PENDING_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [PENDING_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [PENDING_LOG2:0]   count_q, count_d;
  logic                    do_push, do_pop;

  assign tag.full  = (count_q == (PENDING_LOG2+1)'(MAX_PENDING));
  assign tag.empty = (count_q == '0);
  assign tag.count = count_q;
  assign tag.head  = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = tag.pop & ~tag.empty;
  assign do_push = tag.push & (~tag.full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PENDING_LOG2+1)'(1);
      2'b01:   count_d = count_q - (PENDING_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= tag.push_id;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one 64-bit Avalon-MM SDRAM port between the scan-out reader (m0, priority)
// and the rasterizer (m1), with an m1 anti-starvation limit and in-order read return.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MAX_PENDING  = 64,
  parameter int PENDING_LOG2 = 6,
  parameter int M0_RUN_LIMIT = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [28:0]           m0_address,
  input  logic                  m0_read,
  output logic                  m0_waitrequest,
  output logic [63:0]           m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [28:0]           m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [63:0]           m1_writedata,
  input  logic [7:0]            m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [63:0]           m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [28:0]           address,
  output logic [7:0]            burstcount,
  output logic                  read,
  output logic                  write,
  output logic [63:0]           writedata,
  output logic [7:0]            byteenable,
  input  logic                  waitrequest,
  input  logic [63:0]           readdata,
  input  logic                  readdatavalid,
  output logic [PENDING_LOG2:0] pending_reads
);

  localparam int RUN_W = $clog2(M0_RUN_LIMIT + 1);

  logic [1:0]       grant_q, grant_d;
  logic             locked_q, locked_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             m0_req, m1_req, run_at_limit;
  logic             cmd_read, cmd_write, tag_full_block, accept, rvalid_ok;

  sdram_port_arbiter_if #(.PENDING_LOG2(PENDING_LOG2)) tag_if ();

  read_tag_fifo #(
    .MAX_PENDING  (MAX_PENDING),
    .PENDING_LOG2 (PENDING_LOG2)
  ) u_tag_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .tag     (tag_if.slave)
  );

  assign m0_req       = m0_read;
  assign m1_req       = m1_read | m1_write;
  assign run_at_limit = (run_q == RUN_W'(M0_RUN_LIMIT));

  // Grant is decided combinationally each cycle unless a stalled command pins it.
  always_comb begin
    grant_d = GRANT_NONE;
    if (locked_q)                              grant_d = grant_q;
    else if (m1_req && (!m0_req || run_at_limit)) grant_d = GRANT_M1;
    else if (m0_req)                           grant_d = GRANT_M0;
    else if (m1_req)                           grant_d = GRANT_M1;
  end

  always_comb begin
    cmd_read   = 1'b0;
    cmd_write  = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    unique case (grant_d)
      GRANT_M0: begin
        cmd_read   = m0_read;
        address    = m0_address;
        byteenable = M0_BYTEENABLE;
      end
      GRANT_M1: begin
        cmd_write  = m1_write;
        cmd_read   = m1_read & ~m1_write;
        address    = m1_address;
        writedata  = m1_writedata;
        byteenable = m1_byteenable;
      end
      default: ;
    endcase
  end

  // A full tag FIFO holds back reads, except when a return frees a slot this cycle.
  assign tag_full_block = cmd_read & tag_if.full & ~readdatavalid;
  assign read           = cmd_read & ~tag_full_block;
  assign write          = cmd_write;
  assign burstcount     = BURSTCOUNT_ONE;
  assign accept         = (read | write) & ~waitrequest;
  assign locked_d       = (read | write) & waitrequest;

  assign m0_waitrequest = ~((grant_d == GRANT_M0) & accept);
  assign m1_waitrequest = ~((grant_d == GRANT_M1) & accept);

  assign tag_if.push    = read & ~waitrequest;
  assign tag_if.push_id = (grant_d == GRANT_M1) ? MID_M1 : MID_M0;
  assign tag_if.pop     = readdatavalid;
  assign rvalid_ok      = readdatavalid & ~tag_if.empty;

  assign m0_readdata      = readdata;
  assign m1_readdata      = readdata;
  assign m0_readdatavalid = rvalid_ok & (tag_if.head == MID_M0);
  assign m1_readdatavalid = rvalid_ok & (tag_if.head == MID_M1);
  assign pending_reads    = tag_if.count;

  always_comb begin
    run_d = run_q;
    if (!m1_req || (accept && grant_d == GRANT_M1)) run_d = '0;
    else if (accept && grant_d == GRANT_M0 && !run_at_limit) run_d = run_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q  <= GRANT_NONE;
      locked_q <= 1'b0;
      run_q    <= '0;
    end else begin
      grant_q  <= grant_d;
      locked_q <= locked_d;
      run_q    <= run_d;
    end
  end

  a_m1_rw_exclusive : assert property (@(posedge clock) disable iff (!reset_n)
    !(m1_read && m1_write))
    else $error("m1_read and m1_write asserted together");

  a_rvalid_has_tag : assert property (@(posedge clock) disable iff (!reset_n)
    !(readdatavalid && tag_if.empty))
    else $warning("readdatavalid with no outstanding read; response dropped");

endmodule
